// File: rtl/sdivrem_pkg.sv
// sdivrem shared types: FSM state encodings.
// Signed support is enabled by defining SDIVREM_SIGNED_EN.
package sdivrem_pkg;

  typedef enum logic [1:0] {
    S_READY = 2'd0,
    S_NORM  = 2'd1,
    S_SUB   = 2'd2,
    S_FIXUP = 2'd3
  } state_t;

endpackage

// File: rtl/sdivrem_shift.sv
// Shift selector for sdivrem: largest s with (dmag << s) <= rem.
// Built from two leading-one encoders plus one correction compare.
module prio_enc #(
  parameter int W  = 32,
  parameter int WL = 5
) (
  input  logic [W-1:0]  i_in,
  output logic [WL-1:0] o_idx
);

  always_comb begin
    o_idx = '0;
    for (int i = 0; i < W; i++) begin
      if (i_in[i]) o_idx = WL'(i);
    end
  end

endmodule

module divrem_shift #(
  parameter int WIDTH_LOG = 5
) (
  input  logic [(1<<WIDTH_LOG)-1:0] i_rem,
  input  logic [(1<<WIDTH_LOG)-1:0] i_dmag,
  output logic [WIDTH_LOG-1:0]      o_s
);

  localparam int W = 1 << WIDTH_LOG;

  logic [WIDTH_LOG-1:0] w_rm;
  logic [WIDTH_LOG-1:0] w_dm;
  logic [WIDTH_LOG-1:0] w_s0;
  logic [W:0]           w_shv;

  prio_enc #(.W(W), .WL(WIDTH_LOG)) u_enc_rem (
    .i_in  (i_rem),
    .o_idx (w_rm)
  );

  prio_enc #(.W(W), .WL(WIDTH_LOG)) u_enc_den (
    .i_in  (i_dmag),
    .o_idx (w_dm)
  );

  // Aligning leading ones can overshoot by one; the extra bit keeps the compare wrap-free.
  assign w_s0  = w_rm - w_dm;
  assign w_shv = {1'b0, i_dmag} << w_s0;
  assign o_s   = (w_shv > {1'b0, i_rem}) ? w_s0 - WIDTH_LOG'(1) : w_s0;

endmodule

// File: rtl/sdivrem.sv
// Iterative quotient/remainder divider, one quotient bit per cycle.
// Define SDIVREM_SIGNED_EN for two's-complement operation (NORM/FIXUP states).
module sdivrem
  import sdivrem_pkg::*;
#(
  parameter int WIDTH_LOG = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      go,
  input  logic                      is_signed,
  input  logic [(1<<WIDTH_LOG)-1:0] num,
  input  logic [(1<<WIDTH_LOG)-1:0] den,
  output logic                      ready,
  output logic                      error,
  output logic                      overflow,
  output logic [(1<<WIDTH_LOG)-1:0] quot,
  output logic [(1<<WIDTH_LOG)-1:0] rem
);

  localparam int W = 1 << WIDTH_LOG;

`ifdef SDIVREM_SIGNED_EN
  localparam state_t S_FIRST = S_NORM;
  localparam state_t S_LAST  = S_FIXUP;
  localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};
`else
  localparam state_t S_FIRST = S_SUB;
  localparam state_t S_LAST  = S_READY;
`endif

  state_t r_state;
  state_t w_next;

  logic         r_ready;
  logic         r_err;
  logic         r_ovf;
  logic [W-1:0] r_quot;
  logic [W-1:0] r_rem;
  logic [W-1:0] r_dmag;
  logic [W-1:0] r_num;
  logic [W-1:0] r_den;

  logic [WIDTH_LOG-1:0] w_s;
  logic                 w_ge;
  logic                 w_dz;
  logic [W-1:0]         w_bit;
  logic [W-1:0]         w_sub;

`ifdef SDIVREM_SIGNED_EN
  logic r_sn;
  logic r_sd;
`else
  logic w_unused;
  assign w_unused = ^{is_signed, r_num, r_den};
`endif

  divrem_shift #(.WIDTH_LOG(WIDTH_LOG)) u_shift (
    .i_rem  (r_rem),
    .i_dmag (r_dmag),
    .o_s    (w_s)
  );

  assign w_ge  = r_rem >= r_dmag;
  assign w_dz  = den == '0;
  assign w_bit = W'(1) << w_s;
  assign w_sub = r_dmag << w_s;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_READY: if (go && !w_dz) w_next = S_FIRST;
      S_NORM:  w_next = S_SUB;
      S_SUB:   if (!w_ge) w_next = S_LAST;
      S_FIXUP: w_next = S_READY;
      default: w_next = S_READY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_READY;
      r_ready <= 1'b1;
      r_err   <= 1'b0;
      r_ovf   <= 1'b0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_dmag  <= '0;
      r_num   <= '0;
      r_den   <= '0;
`ifdef SDIVREM_SIGNED_EN
      r_sn    <= 1'b0;
      r_sd    <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      r_ready <= (w_next == S_READY);
      unique case (r_state)
        S_READY: begin
          if (go && w_dz) begin
            r_err  <= 1'b1;
            r_ovf  <= 1'b0;
            r_quot <= '1;
            r_rem  <= num;
          end else if (go) begin
            r_err  <= 1'b0;
            r_ovf  <= 1'b0;
            r_num  <= num;
            r_den  <= den;
            r_quot <= '0;
`ifdef SDIVREM_SIGNED_EN
            r_sn   <= is_signed & num[W-1];
            r_sd   <= is_signed & den[W-1];
`else
            r_rem  <= num;
            r_dmag <= den;
`endif
          end
        end
`ifdef SDIVREM_SIGNED_EN
        S_NORM: begin
          r_rem  <= r_sn ? -r_num : r_num;
          r_dmag <= r_sd ? -r_den : r_den;
          r_quot <= '0;
        end
        S_FIXUP: begin
          r_quot <= (r_sn ^ r_sd) ? -r_quot : r_quot;
          r_rem  <= r_sn ? -r_rem : r_rem;
          r_ovf  <= r_sn && r_sd && (r_num == MIN) && (r_den == '1);
        end
`endif
        S_SUB: begin
          if (w_ge) begin
            r_quot <= r_quot | w_bit;
            r_rem  <= r_rem - w_sub;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready    = r_ready;
  assign error    = r_err;
  assign overflow = r_ovf;
  assign quot     = r_quot;
  assign rem      = r_rem;

`ifdef SIM
  logic         r_chk;
  logic [W-1:0] w_arem;

`ifdef SDIVREM_SIGNED_EN
  assign w_arem = r_sn ? -r_rem : r_rem;
`else
  assign w_arem = r_rem;
`endif

  always_ff @(posedge clk) begin
    r_chk <= !rst && (r_state != S_READY) && (w_next == S_READY);
  end

  // Checked one edge after completion, while the results are still held.
  always @(posedge clk) begin
    if (r_chk) begin
      a_rem_lt_den: assert (w_arem < r_dmag);
      a_identity:   assert (W'(r_den * r_quot + r_rem) == r_num);
    end
  end
`endif

endmodule
